seq_rec_param: RTL and testbench

SEQ_REC_PARAM -- requirements
Module: seq_rec_param

---
 rtl/seq_rec_pkg.sv | 18 +
 rtl/seq_rec_hist.sv | 49 ++++
 rtl/seq_rec_param.sv | 82 ++++++++
 tb/tb_seq_rec_param.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seq_rec_pkg.sv
// Shared constants and overlap-mode encoding for the parameterised sequence recogniser.
package seq_rec_pkg;

  localparam int unsigned N_MAX         = 32;
  localparam int unsigned N_DEFAULT     = 3;
  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic {
    OVL_ON  = 1'b0,
    OVL_OFF = 1'b1
  } ovl_mode_e;

  // Maps the integer OVERLAP parameter onto the mode enum (any non-zero value means overlapping).
  function automatic ovl_mode_e ovl_mode_of(input int unsigned ovl);
    return (ovl != 0) ? OVL_ON : OVL_OFF;
  endfunction

endpackage

// File: rtl/seq_rec_hist.sv
// History shift register of the last N-1 accepted bits plus a saturating fill counter.
module seq_rec_hist
  import seq_rec_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         En,
  input  logic         D_in,
  input  logic         clr_fill,
  output logic [N-2:0] hist,
  output logic         fill_full_c
);

  localparam int unsigned FILL_W = $clog2(N);
  localparam logic [FILL_W-1:0] FILL_TOP = FILL_W'(N - 1);

  logic [N-2:0]      hist_d, hist_q;
  logic [FILL_W-1:0] fill_d, fill_q;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (En) begin
      // Newest bit enters at bit 0; the oldest falls off the top.
      hist_d = (N-1)'({hist_q, D_in});
      if (clr_fill) begin
        fill_d = '0;
      end else if (fill_q != FILL_TOP) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist        = hist_q;
  assign fill_full_c = (fill_q == FILL_TOP);

endmodule

// File: rtl/seq_rec_param.sv
// Serial pattern recogniser: Mealy/Moore match flags and a saturating match counter.
module seq_rec_param
  import seq_rec_pkg::*;
#(
  parameter int unsigned N       = N_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned OVERLAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic             D_in,
  input  logic [N-1:0]     pattern,
  input  logic             cnt_clr,
  output logic             D_out_mealy,
  output logic             D_out_moore,
  output logic [CNT_W-1:0] match_cnt
);

  if ((N < 2) || (N > N_MAX)) begin : g_bad_n
    $error("seq_rec_param: N must be in 2..32");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_rec_param: CNT_W must be at least 1");
  end

  localparam ovl_mode_e        OVL_MODE = ovl_mode_of(OVERLAP);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [N-2:0]     hist;
  logic             fill_full_c;
  logic             clr_fill_c;
  logic             moore_d, moore_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  seq_rec_hist #(
    .N(N)
  ) u_hist (
    .clk        (clk),
    .reset      (reset),
    .En         (En),
    .D_in       (D_in),
    .clr_fill   (clr_fill_c),
    .hist       (hist),
    .fill_full_c(fill_full_c)
  );

  // The fill guard keeps reset-time history from ever matching, even for all-zero patterns.
  assign D_out_mealy = En & fill_full_c & ({hist, D_in} == pattern);

  always_comb begin
    clr_fill_c = 1'b0;
    moore_d    = moore_q;
    cnt_d      = cnt_q;
    if (OVL_MODE == OVL_OFF) begin
      clr_fill_c = D_out_mealy;
    end
    if (En) begin
      moore_d = D_out_mealy;
    end
    // Clear beats a coincident match; the count sticks at its maximum.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (D_out_mealy && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      moore_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      moore_q <= moore_d;
      cnt_q   <= cnt_d;
    end
  end

  assign D_out_moore = moore_q;
  assign match_cnt   = cnt_q;

endmodule

// File: tb/tb_seq_rec_param.sv
// Bench for seq_rec_param: three configurations driven in parallel against an arithmetic model.
module tb_seq_rec_param;

  logic       clk = 1'b0;
  logic       reset, en, d_in, cnt_clr;
  logic [2:0] pat3;
  logic [4:0] pat5;

  logic       mealy_a, moore_a, mealy_b, moore_b, mealy_c, moore_c;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b, cnt_c;

  int checks   = 0;
  int failures = 0;

  // Model state per instance: A = N3/CNT_W2/overlap, B = N3/CNT_W8/non-overlap, C = N5/CNT_W8/overlap.
  int          nn    [3] = '{3, 3, 5};
  int          ovl   [3] = '{1, 0, 1};
  int          cmax  [3] = '{3, 255, 255};
  logic [31:0] sh_m  [3];
  int          fresh_m[3];
  int          cnt_m [3];
  logic        moore_m[3];

  always #5 clk = ~clk;

  seq_rec_param #(.N(3), .CNT_W(2), .OVERLAP(1)) u_a (
    .clk(clk), .reset(reset), .En(en), .D_in(d_in), .pattern(pat3), .cnt_clr(cnt_clr),
    .D_out_mealy(mealy_a), .D_out_moore(moore_a), .match_cnt(cnt_a));

  seq_rec_param #(.N(3), .CNT_W(8), .OVERLAP(0)) u_b (
    .clk(clk), .reset(reset), .En(en), .D_in(d_in), .pattern(pat3), .cnt_clr(cnt_clr),
    .D_out_mealy(mealy_b), .D_out_moore(moore_b), .match_cnt(cnt_b));

  seq_rec_param #(.N(5), .CNT_W(8), .OVERLAP(1)) u_c (
    .clk(clk), .reset(reset), .En(en), .D_in(d_in), .pattern(pat5), .cnt_clr(cnt_clr),
    .D_out_mealy(mealy_c), .D_out_moore(moore_c), .match_cnt(cnt_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected match: N bits accepted since the last clear, and the last N bits (newest = D_in) equal the pattern.
  function automatic logic exp_mealy(input int i);
    logic [31:0] pat, mask, window;
    pat    = (i == 2) ? 32'(pat5) : 32'(pat3);
    mask   = (nn[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << nn[i]) - 32'd1);
    window = (sh_m[i] << 1) | 32'(d_in);
    return en && (fresh_m[i] >= nn[i] - 1) && ((window & mask) == (pat & mask));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      sh_m[i] = '0; fresh_m[i] = 0; cnt_m[i] = 0; moore_m[i] = 1'b0;
    end
  endtask

  // One clock: Mealy checked before the edge, registered outputs after it.
  task automatic tick();
    logic m [3];
    @(negedge clk);
    for (int i = 0; i < 3; i++) m[i] = exp_mealy(i);
    check("mealy_a", 32'(mealy_a), 32'(m[0]));
    check("mealy_b", 32'(mealy_b), 32'(m[1]));
    check("mealy_c", 32'(mealy_c), 32'(m[2]));
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (cnt_clr) cnt_m[i] = 0;
        else if (m[i] && cnt_m[i] < cmax[i]) cnt_m[i]++;
        if (en) begin
          moore_m[i] = m[i];
          sh_m[i]    = (sh_m[i] << 1) | 32'(d_in);
          if (m[i] && ovl[i] == 0) fresh_m[i] = 0;
          else if (fresh_m[i] < 64) fresh_m[i]++;
        end
      end
    end
    check("moore_a", 32'(moore_a), 32'(moore_m[0]));
    check("moore_b", 32'(moore_b), 32'(moore_m[1]));
    check("moore_c", 32'(moore_c), 32'(moore_m[2]));
    check("cnt_a", 32'(cnt_a), 32'(cnt_m[0]));
    check("cnt_b", 32'(cnt_b), 32'(cnt_m[1]));
    check("cnt_c", 32'(cnt_c), 32'(cnt_m[2]));
  endtask

  task automatic step(input logic e, input logic d);
    en = e; d_in = d; reset = 1'b0; cnt_clr = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    en = 1'b0; d_in = 1'b0; reset = 1'b1; cnt_clr = 1'b0;
    tick();
  endtask

  initial begin
    logic [5:0] bits6;
    model_reset();
    reset = 1'b1; en = 1'b0; d_in = 1'b0; cnt_clr = 1'b0; pat3 = 3'b111; pat5 = 5'b10110;
    tick();
    do_reset();
    check("rst_moore_a", 32'(moore_a), 32'd0);
    check("rst_cnt_b", 32'(cnt_b), 32'd0);

    // Stream 0,1,1,1,1,0 on pattern 111: two overlapping matches, one non-overlapping.
    bits6 = 6'b011110;
    for (int k = 5; k >= 0; k--) step(1'b1, bits6[k]);
    check("dir_cnt_ovl", 32'(cnt_a), 32'd2);
    check("dir_cnt_novl", 32'(cnt_b), 32'd1);

    // All-zero pattern right after reset must wait for three real bits.
    pat3 = 3'b000;
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("zero_pat_early", 32'(cnt_a), 32'd0);
    step(1'b1, 1'b0);
    check("zero_pat_hit", 32'(cnt_a), 32'd1);

    // Reset in mid-pattern discards the partial match.
    pat3 = 3'b111;
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("mid_rst_none", 32'(cnt_a), 32'd0);
    step(1'b1, 1'b1);
    check("mid_rst_hit", 32'(cnt_a), 32'd1);

    // En low stalls history and the Moore flag.
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    check("stall_hit", 32'(moore_a), 32'd1);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0);
    check("stall_hold", 32'(moore_a), 32'd1);

    // Eight ones give six overlapping matches; the 2-bit counter sticks at 3.
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1);
    check("sat_cnt", 32'(cnt_a), 32'd3);
    en = 1'b1; d_in = 1'b1; reset = 1'b0; cnt_clr = 1'b1;
    tick();
    check("clr_wins", 32'(cnt_a), 32'd0);

    // Randomised traffic with occasional reset, clear and pattern changes.
    for (int k = 0; k < 600; k++) begin
      reset   = ($urandom_range(0, 59) == 0);
      en      = ($urandom_range(0, 3) != 0);
      d_in    = 1'($urandom_range(0, 1));
      cnt_clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 24) == 0) pat3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) pat5 = 5'($urandom_range(0, 31));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
